pc_next_unit: RTL and testbench
===============================

Name: pc_next_unit

Overview:
- Registered program-counter generator for the RV64 fetch stage.
- Evaluates branch conditions and computes branch, JAL and JALR targets.
- Handles stalls, holds a redirect that arrives while the PC is stalled, and traps misaligned targets.
- Sits between the EX-stage branch logic and the instruction-memory address port.

Parameters:
XLEN, 64, datapath/PC width in bits
RESET_VECTOR, 64'h0, PC value loaded by reset
TRAP_VECTOR, 64'h100, PC loaded on a misaligned-target trap
IMM_SHIFT, 1, left shift applied to imm for branch/JAL targets

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high reset
stall  input  1  hold PC (IF/ID not accepting)
branch  input  1  EX holds a conditional branch
jump  input  1  EX holds JAL
jalr  input  1  EX holds JALR
funct3  input  3  branch condition select
rs1_val  input  XLEN  operand 1 (compare, JALR base)
rs2_val  input  XLEN  operand 2 (compare)
imm  input  XLEN  sign-extended immediate
ex_pc  input  XLEN  PC of the EX-stage instruction
pc_o  output  XLEN  current fetch PC (registered)
pc_plus4_o  output  XLEN  pc_o + 4 (combinational from pc_o)
pc_valid_o  output  1  pc_o is a real fetch address
redirect_o  output  1  1-cycle pulse: pc_o was loaded from a redirect (flush IF/ID)
misalign_o  output  1  1-cycle pulse: trap taken
bad_addr_o  output  XLEN  last faulting target

Behaviour:
- Reset (any edge with reset=1): state=BOOT, pc_o=RESET_VECTOR, pc_valid_o=0, redirect_o=0, misalign_o=0, bad_addr_o=0, pending target cleared. Reset overrides everything, including mid-PEND.
- Condition cond by funct3:
  - 000 eq, 001 ne
  - 100 signed lt, 101 signed ge
  - 110 unsigned lt, 111 unsigned ge
  - 010/011: not taken
- take = jump | jalr | (branch & cond). If more than one of jump/jalr/branch is set, priority is jalr > jump > branch.
- Targets:
  - branch/JAL: ex_pc + (imm << IMM_SHIFT), modulo 2^XLEN.
  - JALR: (rs1_val + imm) with bit0 cleared.
  - Target is misaligned when target[1]=1.
- BOOT: all inputs ignored. Next edge: state=RUN, pc_o stays RESET_VECTOR, pc_valid_o=1.
- RUN, evaluated at each edge, first match wins:
  1. take & misaligned: pc_o=TRAP_VECTOR, bad_addr_o=target, misalign_o=1 for one cycle. Stall is ignored.
  2. take & stall: latch target into the pending register, state=PEND, pc_o held.
  3. take & !stall: pc_o=target, redirect_o=1 for one cycle.
  4. stall: pc_o held.
  5. otherwise: pc_o=pc_o+4, wrapping at 2^XLEN.
- PEND:
  - branch/jump/jalr are ignored; the holding instruction is the redirecting one.
  - stall=1: hold.
  - stall=0: pc_o=pending target, redirect_o=1, state=RUN.
- redirect_o and misalign_o are 0 in every cycle not listed above. pc_valid_o=1 in RUN and PEND.
- Latency: a redirect is visible on pc_o one edge after take is sampled with stall=0.

Test Plan:
- Reset release → pc_o=0 with valid=0 during reset; 0 with valid=1 for one cycle; then 4, 8, 12 on consecutive edges.
- Taken branch: branch=1, funct3=000, rs1=rs2=5, ex_pc=0x40, imm=0x10 → next pc_o=0x60, redirect_o=1 for one cycle. Same inputs with funct3=001 → pc_o=prev+4, redirect_o=0.
- Signed vs unsigned compare: rs1=0xFFFF_FFFF_FFFF_FFFF, rs2=1. funct3=100 → taken. funct3=110 → not taken.
- JALR: rs1=0x1001, imm=0x4 → pc_o=0x1004, redirect_o=1. With rs1=0x1003 → target 0x1006 is misaligned: pc_o=0x100, misalign_o=1, bad_addr_o=0x1006.
- Redirect during stall: stall=1 with a taken branch to 0x200, then stall held 3 cycles (branch deasserted) → pc_o unchanged throughout. First cycle after stall=0 → pc_o=0x200, redirect_o=1.
- Reset asserted while in PEND → pc_o=RESET_VECTOR, the pending target is discarded, and after release no redirect_o occurs.

Source files
------------

// File: rtl/pc_next_unit.sv
// Registered fetch-PC generator for the RV64 front end: resolves branch/JAL/JALR
// redirects from EX, holds a redirect across stalls, and traps misaligned targets.
module pc_next_unit #(
   parameter int unsigned           XLEN         = 64,
   parameter logic [XLEN-1:0]       RESET_VECTOR = '0,
   parameter logic [XLEN-1:0]       TRAP_VECTOR  = XLEN'('h100),
   parameter int unsigned           IMM_SHIFT    = 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            stall,
   input  logic            branch,
   input  logic            jump,
   input  logic            jalr,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] rs1_val,
   input  logic [XLEN-1:0] rs2_val,
   input  logic [XLEN-1:0] imm,
   input  logic [XLEN-1:0] ex_pc,
   output logic [XLEN-1:0] pc_o,
   output logic [XLEN-1:0] pc_plus4_o,
   output logic            pc_valid_o,
   output logic            redirect_o,
   output logic            misalign_o,
   output logic [XLEN-1:0] bad_addr_o
);

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      PEND = 2'd2
   } state_e;

   state_e          state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] pend_q, pend_d;
   logic [XLEN-1:0] bad_addr_q, bad_addr_d;
   logic            pc_valid_q, pc_valid_d;
   logic            redirect_q, redirect_d;
   logic            misalign_q, misalign_d;

   logic            cond;
   logic            take;
   logic [XLEN-1:0] br_tgt;
   logic [XLEN-1:0] jalr_sum;
   logic [XLEN-1:0] target;
   logic            tgt_misaligned;

   // Branch condition and redirect target selection (jalr > jump > branch)
   always_comb begin
      cond = 1'b0;
      unique case (funct3)
         3'b000:  cond = (rs1_val == rs2_val);
         3'b001:  cond = (rs1_val != rs2_val);
         3'b100:  cond = ($signed(rs1_val) <  $signed(rs2_val));
         3'b101:  cond = ($signed(rs1_val) >= $signed(rs2_val));
         3'b110:  cond = (rs1_val <  rs2_val);
         3'b111:  cond = (rs1_val >= rs2_val);
         default: cond = 1'b0;
      endcase

      br_tgt   = ex_pc + (imm << IMM_SHIFT);
      jalr_sum = rs1_val + imm;
      target   = jalr ? {jalr_sum[XLEN-1:1], 1'b0} : br_tgt;
      take     = jalr | jump | (branch & cond);
      tgt_misaligned = target[1];
   end

   // Next-state and next-output logic
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      pend_d     = pend_q;
      bad_addr_d = bad_addr_q;
      pc_valid_d = 1'b1;
      redirect_d = 1'b0;
      misalign_d = 1'b0;

      unique case (state_q)
         BOOT: begin
            state_d = RUN;
         end
         RUN: begin
            if (take && tgt_misaligned) begin
               pc_d       = TRAP_VECTOR;
               bad_addr_d = target;
               misalign_d = 1'b1;
            end else if (take && stall) begin
               pend_d  = target;
               state_d = PEND;
            end else if (take) begin
               pc_d       = target;
               redirect_d = 1'b1;
            end else if (!stall) begin
               pc_d = pc_q + XLEN'(4);
            end
         end
         PEND: begin
            // Control inputs belong to the instruction already redirecting; ignore them.
            if (!stall) begin
               pc_d       = pend_q;
               redirect_d = 1'b1;
               state_d    = RUN;
            end
         end
         default: begin
            state_d = BOOT;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= BOOT;
         pc_q       <= RESET_VECTOR;
         pend_q     <= '0;
         bad_addr_q <= '0;
         pc_valid_q <= 1'b0;
         redirect_q <= 1'b0;
         misalign_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         pend_q     <= pend_d;
         bad_addr_q <= bad_addr_d;
         pc_valid_q <= pc_valid_d;
         redirect_q <= redirect_d;
         misalign_q <= misalign_d;
      end
   end

   assign pc_o       = pc_q;
   assign pc_plus4_o = pc_q + XLEN'(4);
   assign pc_valid_o = pc_valid_q;
   assign redirect_o = redirect_q;
   assign misalign_o = misalign_q;
   assign bad_addr_o = bad_addr_q;

endmodule

// File: tb/tb_pc_next_unit.sv
// Directed bench for pc_next_unit: hand-computed PC sequences for sequential
// fetch, branch conditions, JAL/JALR, traps, stalled redirects and reset.
module tb_pc_next_unit;

   localparam int unsigned XLEN = 64;

   logic            clk = 1'b0;
   logic            reset, stall, branch, jump, jalr;
   logic [2:0]      funct3;
   logic [XLEN-1:0] rs1_val, rs2_val, imm, ex_pc;
   logic [XLEN-1:0] pc_o, pc_plus4_o, bad_addr_o;
   logic            pc_valid_o, redirect_o, misalign_o;

   int n_tests = 0;
   int n_fail  = 0;

   pc_next_unit dut (
      .clk        (clk),
      .reset      (reset),
      .stall      (stall),
      .branch     (branch),
      .jump       (jump),
      .jalr       (jalr),
      .funct3     (funct3),
      .rs1_val    (rs1_val),
      .rs2_val    (rs2_val),
      .imm        (imm),
      .ex_pc      (ex_pc),
      .pc_o       (pc_o),
      .pc_plus4_o (pc_plus4_o),
      .pc_valid_o (pc_valid_o),
      .redirect_o (redirect_o),
      .misalign_o (misalign_o),
      .bad_addr_o (bad_addr_o)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // pc, valid, redirect, misalign in one call
   task automatic check_pc(input string tag, input logic [XLEN-1:0] pc,
                           input logic v, input logic r, input logic m);
      check({tag, ".pc"},       pc_o,             pc);
      check({tag, ".valid"},    XLEN'(pc_valid_o), XLEN'(v));
      check({tag, ".redirect"}, XLEN'(redirect_o), XLEN'(r));
      check({tag, ".misalign"}, XLEN'(misalign_o), XLEN'(m));
   endtask

   initial begin
      reset = 1'b1; stall = 1'b0; branch = 1'b0; jump = 1'b0; jalr = 1'b0;
      funct3 = 3'b000; rs1_val = '0; rs2_val = '0; imm = '0; ex_pc = '0;

      step(); step();
      check_pc("reset", 64'h0, 1'b0, 1'b0, 1'b0);
      check("reset.bad_addr", bad_addr_o, 64'h0);

      reset = 1'b0;
      step(); check_pc("boot", 64'h0, 1'b1, 1'b0, 1'b0);
      step(); check_pc("seq4", 64'h4, 1'b1, 1'b0, 1'b0);
      check("seq4.plus4", pc_plus4_o, 64'h8);
      step(); check_pc("seq8", 64'h8, 1'b1, 1'b0, 1'b0);
      step(); check_pc("seq12", 64'hC, 1'b1, 1'b0, 1'b0);

      // beq taken: 0x40 + (0x10<<1)
      branch = 1'b1; funct3 = 3'b000; rs1_val = 64'd5; rs2_val = 64'd5;
      ex_pc = 64'h40; imm = 64'h10;
      step(); check_pc("beq_taken", 64'h60, 1'b1, 1'b1, 1'b0);
      funct3 = 3'b001;
      step(); check_pc("bne_not", 64'h64, 1'b1, 1'b0, 1'b0);

      // Signed vs unsigned compares of -1 against 1
      rs1_val = '1; rs2_val = 64'd1;
      funct3 = 3'b100; step(); check_pc("blt_taken", 64'h60, 1'b1, 1'b1, 1'b0);
      funct3 = 3'b110; step(); check_pc("bltu_not", 64'h64, 1'b1, 1'b0, 1'b0);
      funct3 = 3'b101; step(); check_pc("bge_not", 64'h68, 1'b1, 1'b0, 1'b0);
      funct3 = 3'b111; step(); check_pc("bgeu_taken", 64'h60, 1'b1, 1'b1, 1'b0);
      funct3 = 3'b010; step(); check_pc("f010_not", 64'h64, 1'b1, 1'b0, 1'b0);
      branch = 1'b0;

      // JALR aligned and misaligned
      jalr = 1'b1; rs1_val = 64'h1001; imm = 64'h4;
      step(); check_pc("jalr", 64'h1004, 1'b1, 1'b1, 1'b0);
      rs1_val = 64'h1003;
      step(); check_pc("jalr_mis", 64'h100, 1'b1, 1'b0, 1'b1);
      check("jalr_mis.bad_addr", bad_addr_o, 64'h1006);
      jalr = 1'b0;
      step(); check_pc("after_trap", 64'h104, 1'b1, 1'b0, 1'b0);
      check("after_trap.bad_addr", bad_addr_o, 64'h1006);

      // jalr wins over jump
      jalr = 1'b1; jump = 1'b1; rs1_val = 64'h2000; imm = 64'h0; ex_pc = 64'h40;
      step(); check_pc("prio_jalr", 64'h2000, 1'b1, 1'b1, 1'b0);
      jalr = 1'b0; ex_pc = 64'h300; imm = 64'h8;
      step(); check_pc("jal", 64'h310, 1'b1, 1'b1, 1'b0);
      jump = 1'b0;

      // Redirect during stall: 0x100 + (0x80<<1) = 0x200
      branch = 1'b1; funct3 = 3'b000; rs1_val = 64'd7; rs2_val = 64'd7;
      ex_pc = 64'h100; imm = 64'h80; stall = 1'b1;
      step(); check_pc("pend_enter", 64'h310, 1'b1, 1'b0, 1'b0);
      branch = 1'b0;
      step(); check_pc("pend_hold1", 64'h310, 1'b1, 1'b0, 1'b0);
      jalr = 1'b1; rs1_val = 64'h1003; imm = 64'h4;
      step(); check_pc("pend_ign_jalr", 64'h310, 1'b1, 1'b0, 1'b0);
      jalr = 1'b0;
      step(); check_pc("pend_hold3", 64'h310, 1'b1, 1'b0, 1'b0);
      stall = 1'b0;
      step(); check_pc("pend_release", 64'h200, 1'b1, 1'b1, 1'b0);
      step(); check_pc("post_pend", 64'h204, 1'b1, 1'b0, 1'b0);
      stall = 1'b1;
      step(); check_pc("plain_stall", 64'h204, 1'b1, 1'b0, 1'b0);

      // Misaligned trap ignores stall: 0 + (1<<1) = 2
      jump = 1'b1; ex_pc = 64'h0; imm = 64'h1;
      step(); check_pc("trap_stall", 64'h100, 1'b1, 1'b0, 1'b1);
      check("trap_stall.bad_addr", bad_addr_o, 64'h2);
      jump = 1'b0;

      // Reset while PEND discards the pending target
      branch = 1'b1; rs1_val = 64'd1; rs2_val = 64'd1; ex_pc = 64'h100; imm = 64'h80;
      step(); check_pc("pend2_enter", 64'h100, 1'b1, 1'b0, 1'b0);
      branch = 1'b0; reset = 1'b1;
      step(); check_pc("pend_reset", 64'h0, 1'b0, 1'b0, 1'b0);
      check("pend_reset.bad_addr", bad_addr_o, 64'h0);
      reset = 1'b0; stall = 1'b0;
      step(); check_pc("reboot", 64'h0, 1'b1, 1'b0, 1'b0);
      step(); check_pc("reboot4", 64'h4, 1'b1, 1'b0, 1'b0);
      step(); check_pc("reboot8", 64'h8, 1'b1, 1'b0, 1'b0);

      // Wrap of pc and pc_plus4 at 2^XLEN
      jalr = 1'b1; rs1_val = 64'hFFFF_FFFF_FFFF_FFFC; imm = 64'h0;
      step(); check_pc("wrap_tgt", 64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 1'b1, 1'b0);
      check("wrap.plus4", pc_plus4_o, 64'h0);
      jalr = 1'b0;
      step(); check_pc("wrap_seq", 64'h0, 1'b1, 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
